// File: rtl/camera_cfg_seq.sv
// rtl/camera_cfg_seq.sv - OV7670 settings ROM to SCCB write-request sequencer
// Define CAM_CFG_RETRY_EN to re-issue a NACKed entry up to 3 extra times before aborting.
module camera_cfg_seq #(
  parameter int unsigned DELAY_CYCLES = 240000,
  parameter logic [7:0]  SCCB_ID      = 8'h42,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  output logic [7:0]  o_Rom_Addr,
  input  logic [15:0] i_Rom_Data,
  output logic        o_Sccb_Start,
  output logic [7:0]  o_Sccb_Id,
  output logic [7:0]  o_Sccb_Reg,
  output logic [7:0]  o_Sccb_Val,
  input  logic        i_Sccb_Busy,
  input  logic        i_Sccb_Ack_Err,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Err,
  output logic [7:0]  o_Err_Addr
);

  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH_A,
    ST_FETCH_B,
    ST_DECODE,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DELAY,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [15:0]     word_q, word_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      val_q, val_d;
  logic [DW-1:0]   dly_q, dly_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      err_addr_q, err_addr_d;
  logic            go_err;
`ifdef CAM_CFG_RETRY_EN
  logic [1:0]      retry_q, retry_d;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    word_d     = word_q;
    reg_d      = reg_q;
    val_d      = val_q;
    dly_d      = dly_q;
    tmo_d      = tmo_q;
    done_d     = done_q;
    err_d      = err_q;
    err_addr_d = err_addr_q;
    go_err     = 1'b0;
`ifdef CAM_CFG_RETRY_EN
    retry_d    = retry_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_Start) begin
          addr_d     = 8'd0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_addr_d = 8'd0;
          state_d    = ST_FETCH_A;
        end
      end
      ST_FETCH_A: state_d = ST_FETCH_B;
      // ROM output is registered: the word for addr_q is only valid here.
      ST_FETCH_B: begin
        word_d  = i_Rom_Data;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (word_q == 16'hFFFF) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (word_q == 16'hFFF0) begin
          dly_d   = DW'(DELAY_CYCLES - 1);
          state_d = ST_DELAY;
        end else begin
          reg_d   = word_q[15:8];
          val_d   = word_q[7:0];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_HI;
      end
      // Busy is tested before the timeout so a same-cycle rise still counts.
      ST_WAIT_HI: begin
        if (i_Sccb_Busy) begin
          state_d = ST_WAIT_LO;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          go_err = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_WAIT_LO: begin
        if (!i_Sccb_Busy) begin
          if (!i_Sccb_Ack_Err) begin
`ifdef CAM_CFG_RETRY_EN
            retry_d = 2'd0;
`endif
            state_d = ST_NEXT;
          end else begin
`ifdef CAM_CFG_RETRY_EN
            if (retry_q == 2'd3) begin
              go_err = 1'b1;
            end else begin
              retry_d = retry_q + 1'b1;
              state_d = ST_ISSUE;
            end
`else
            go_err = 1'b1;
`endif
          end
        end
      end
      ST_DELAY: begin
        if (dly_q == '0) begin
          state_d = ST_NEXT;
        end else begin
          dly_d = dly_q - 1'b1;
        end
      end
      ST_NEXT: begin
`ifdef CAM_CFG_RETRY_EN
        retry_d = 2'd0;
`endif
        if (addr_q == 8'hFF) begin
          go_err = 1'b1;
        end else begin
          addr_d  = addr_q + 8'd1;
          state_d = ST_FETCH_A;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_err) begin
      err_d      = 1'b1;
      err_addr_d = addr_q;
      state_d    = ST_ERR;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 8'd0;
      word_q     <= 16'd0;
      reg_q      <= 8'd0;
      val_q      <= 8'd0;
      dly_q      <= '0;
      tmo_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= 8'd0;
`ifdef CAM_CFG_RETRY_EN
      retry_q    <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      reg_q      <= reg_d;
      val_q      <= val_d;
      dly_q      <= dly_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
`ifdef CAM_CFG_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign o_Rom_Addr   = addr_q;
  assign o_Sccb_Start = (state_q == ST_ISSUE);
  assign o_Sccb_Id    = SCCB_ID;
  assign o_Sccb_Reg   = reg_q;
  assign o_Sccb_Val   = val_q;
  assign o_Busy       = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign o_Done       = done_q;
  assign o_Err        = err_q;
  assign o_Err_Addr   = err_addr_q;

endmodule
